// File: rtl/twos_comp_seq.sv
// Digit-serial two's-complement engine: pass, negate, absolute value and ones'
// complement on a WIDTH-bit operand, DIGIT bits per clock, LSB digit first.
module twos_comp_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] opnd, part, part_nx;
  logic [CW-1:0]    cnt;
  logic             inv, neg, carry;
  logic             go, last, eff_neg;
  logic [DIGIT-1:0] digit;
  logic [DIGIT:0]   sum;

  assign go      = (state != RUN) && start;
  assign last    = (cnt == CW'(N-1));
  assign eff_neg = (mode == 2'b01) || ((mode == 2'b10) && in[WIDTH-1]);

  // Status flags are decoded straight from the state register.
  assign busy = (state == RUN);
  assign done = (state == FIN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIN;
      FIN:     state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Invert-and-add on the current digit; carry ripples across clocks.
  always_comb begin
    digit   = opnd[cnt*DIGIT +: DIGIT];
    sum     = {1'b0, ~digit} + {{DIGIT{1'b0}}, carry};
    part_nx = part;
    part_nx[cnt*DIGIT +: DIGIT] = inv ? sum[DIGIT-1:0] : digit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opnd     <= '0;
      part     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      inv      <= 1'b0;
      neg      <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (go) begin
      opnd  <= in;
      part  <= '0;
      cnt   <= '0;
      carry <= eff_neg;
      neg   <= eff_neg;
      inv   <= eff_neg || (mode == 2'b11);
    end else if (state == RUN) begin
      part <= part_nx;
      cnt  <= last ? '0 : cnt + 1'b1;
      if (inv) carry <= sum[DIGIT];
      if (last) begin
        result   <= part_nx;
        overflow <= neg && (opnd == MOST_NEG);
      end
    end
  end
endmodule

// File: tb/tb_twos_comp_seq.sv
// Bench for twos_comp_seq: three instances (8/2, 16/1, 16/4) checked every cycle
// against a countdown/arithmetic model, plus directed literal expectations.
module tb_twos_comp_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start [3];
  logic [1:0]  mode  [3];
  logic [15:0] din   [3];
  logic        busy  [3];
  logic        done  [3];
  logic        ovf   [3];
  logic [15:0] res   [3];

  logic [7:0]  r0;
  logic [15:0] r1, r2;
  logic        b0, b1, b2, d0, d1, d2, o0, o1, o2;
  assign res[0] = {8'h00, r0};
  assign res[1] = r1;
  assign res[2] = r2;
  assign busy[0] = b0; assign busy[1] = b1; assign busy[2] = b2;
  assign done[0] = d0; assign done[1] = d1; assign done[2] = d2;
  assign ovf[0]  = o0; assign ovf[1]  = o1; assign ovf[2]  = o2;

  twos_comp_seq #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .mode(mode[0]), .in(din[0][7:0]),
    .busy(b0), .done(d0), .result(r0), .overflow(o0));
  twos_comp_seq #(.WIDTH(16), .DIGIT(1)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .mode(mode[1]), .in(din[1]),
    .busy(b1), .done(d1), .result(r1), .overflow(o1));
  twos_comp_seq #(.WIDTH(16), .DIGIT(4)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .mode(mode[2]), .in(din[2]),
    .busy(b2), .done(d2), .result(r2), .overflow(o2));

  int W  [3] = '{8, 16, 16};
  int NN [3] = '{4, 16, 4};

  int checks = 0;
  int errors = 0;
  logic live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // {overflow, result} from the arithmetic meaning of each mode.
  function automatic logic [16:0] model(input int w, input logic [1:0] m, input logic [15:0] x);
    logic [31:0] mask, v, msbv, r;
    logic        ng;
    mask = (32'd1 << w) - 32'd1;
    v    = {16'h0, x} & mask;
    msbv = 32'd1 << (w - 1);
    ng   = (m == 2'b01) || (m == 2'b10 && (v & msbv) != 0);
    if (m == 2'b11)  r = ~v & mask;
    else if (ng)     r = (32'd0 - v) & mask;
    else             r = v;
    return {ng && (v == msbv), r[15:0]};
  endfunction

  // Cycle model: a run occupies NN cycles, then one done cycle during which
  // a new start may be accepted.
  int          m_cnt  [3];
  logic        m_busy [3], m_done [3], m_ovf [3], p_ovf [3];
  logic [15:0] m_res  [3], p_res [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i] <= 0; m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
        m_res[i] <= '0; m_ovf[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_cnt[i] > 1) m_cnt[i] <= m_cnt[i] - 1;
        else if (m_cnt[i] == 1) begin
          m_cnt[i] <= 0; m_busy[i] <= 1'b0; m_done[i] <= 1'b1;
          m_res[i] <= p_res[i]; m_ovf[i] <= p_ovf[i];
        end else if (start[i]) begin
          {p_ovf[i], p_res[i]} <= model(W[i], mode[i], din[i]);
          m_cnt[i] <= NN[i]; m_busy[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d_busy", i), 32'(busy[i]), 32'(m_busy[i]));
        chk($sformatf("u%0d_done", i), 32'(done[i]), 32'(m_done[i]));
        chk($sformatf("u%0d_result", i), 32'(res[i]), 32'(m_res[i]));
        chk($sformatf("u%0d_ovf", i), 32'(ovf[i]), 32'(m_ovf[i]));
      end
    end
  end

  task automatic wait_done(input int i, input string name, output int nbusy);
    logic got;
    got = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (done[i]) got = 1'b1;
      else if (busy[i]) nbusy++;
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic op(input int i, input logic [1:0] m, input logic [15:0] x,
                    input logic [15:0] er, input logic eo, input int eb, input string name);
    int nb;
    @(posedge clk); #1;
    start[i] = 1'b1; mode[i] = m; din[i] = x;
    @(posedge clk); #1;
    start[i] = 1'b0;
    wait_done(i, name, nb);
    chk({name, "_result"}, 32'(res[i]), 32'(er));
    chk({name, "_ovf"}, 32'(ovf[i]), 32'(eo));
    chk({name, "_busy_cycles"}, nb, eb);
  endtask

  task automatic no_done(input int cycles, input string name);
    int nd;
    nd = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    chk(name, nd, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; mode[i] = 2'b00; din[i] = 16'h0;
    end
    @(posedge clk);
    live = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
      chk($sformatf("rst_done%0d", i), 32'(done[i]), 0);
      chk($sformatf("rst_res%0d", i), 32'(res[i]), 0);
      chk($sformatf("rst_ovf%0d", i), 32'(ovf[i]), 0);
    end
    chk("model_neg05", 32'(model(8, 2'b01, 16'h05)), 32'h000FB);
    chk("model_abs80", 32'(model(8, 2'b10, 16'h80)), 32'h10080);
    @(posedge clk); #1;
    reset = 1'b0;

    op(0, 2'b01, 16'h05, 16'hFB, 1'b0, 4, "neg05");
    op(0, 2'b10, 16'hF6, 16'h0A, 1'b0, 4, "abs_f6");
    op(0, 2'b10, 16'h80, 16'h80, 1'b1, 4, "abs_80");
    op(0, 2'b10, 16'h3C, 16'h3C, 1'b0, 4, "abs_3c");
    op(0, 2'b01, 16'h00, 16'h00, 1'b0, 4, "neg00");
    op(0, 2'b11, 16'hA5, 16'h5A, 1'b0, 4, "ones_a5");
    op(0, 2'b00, 16'h7E, 16'h7E, 1'b0, 4, "pass_7e");
    op(0, 2'b01, 16'h80, 16'h80, 1'b1, 4, "neg80");

    // START mid-run must be ignored and not queued.
    @(posedge clk); #1;
    start[0] = 1'b1; mode[0] = 2'b01; din[0] = 16'h05;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    start[0] = 1'b1; mode[0] = 2'b00; din[0] = 16'h01;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_done(0, "midrun", nb);
    chk("midrun_result", 32'(res[0]), 32'hFB);
    no_done(8, "midrun_no_extra_done");

    // START held across FIN: next run starts with no idle cycle.
    @(posedge clk); #1;
    start[0] = 1'b1; mode[0] = 2'b01; din[0] = 16'h05;
    wait_done(0, "b2b_first", nb);
    chk("b2b_first_result", 32'(res[0]), 32'hFB);
    din[0] = 16'h03;
    @(negedge clk);
    chk("b2b_nogap_busy", 32'(busy[0]), 1);
    chk("b2b_hold_result", 32'(res[0]), 32'hFB);
    wait_done(0, "b2b_second", nb);
    start[0] = 1'b0;
    chk("b2b_second_result", 32'(res[0]), 32'hFD);
    chk("b2b_second_busy", nb, 3);
    @(posedge clk); #1;

    // Reset during the second RUN cycle abandons the run.
    @(posedge clk); #1;
    start[0] = 1'b1; mode[0] = 2'b01; din[0] = 16'h22;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstrun_busy", 32'(busy[0]), 0);
    chk("rstrun_done", 32'(done[0]), 0);
    chk("rstrun_result", 32'(res[0]), 0);
    chk("rstrun_ovf", 32'(ovf[0]), 0);
    no_done(8, "rstrun_no_done");
    op(0, 2'b01, 16'h01, 16'hFF, 1'b0, 4, "neg01");

    op(1, 2'b01, 16'h8000, 16'h8000, 1'b1, 16, "w16d1_neg8000");
    op(1, 2'b10, 16'hFFFF, 16'h0001, 1'b0, 16, "w16d1_absffff");
    op(2, 2'b01, 16'h1234, 16'hEDCC, 1'b0, 4, "w16d4_neg1234");
    op(2, 2'b11, 16'h00FF, 16'hFF00, 1'b0, 4, "w16d4_ones00ff");

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
